maj_tt_scan: RTL

MAJ_TT_SCAN -- requirements
Module: maj_tt_scan

---
 rtl/maj_tt_scan.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/maj_tt_scan.sv
// Programmable network of 3-input majority gates with a truth-table scanner and a direct evaluation port.
// Optional macro MAJ_INV_EN adds a per-operand inversion bit to every gate.
module maj_tt_scan #(
    parameter int unsigned N_IN    = 7,
    parameter int unsigned N_GATES = 6,
    localparam int unsigned N_SRC  = N_IN + 1 + N_GATES,
    localparam int unsigned SEL_W  = $clog2(N_SRC),
    localparam int unsigned TT_W   = 2 ** N_IN,
    localparam int unsigned GATE_W = (N_GATES > 1) ? $clog2(N_GATES) : 1,
`ifdef MAJ_INV_EN
    localparam int unsigned OP_W   = 3 * SEL_W + 3
`else
    localparam int unsigned OP_W   = 3 * SEL_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [GATE_W-1:0] cfg_gate,
    input  logic [OP_W-1:0]   cfg_op,
    output logic              cfg_err,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt,
    input  logic [N_IN-1:0]   eval_x,
    output logic              eval_y
);

    localparam int unsigned V_W = 2 ** SEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                           r_state;
    logic [N_IN-1:0]                  r_cnt;
    logic                             r_busy;
    logic                             r_done;
    logic                             r_cfg_err;
    logic [TT_W-1:0]                  r_tt;
    logic                             r_eval_y;
    logic [N_GATES-1:0][3*SEL_W-1:0]  r_sel;
    logic [N_GATES-1:0][2:0]          w_inv;
    logic                             w_cfg_ok;
    logic                             w_scan_y;
    logic                             w_eval_y;

`ifdef MAJ_INV_EN
    logic [N_GATES-1:0][2:0]          r_inv;
    assign w_inv = r_inv;
`else
    assign w_inv = '0;
`endif

    // Resolve the whole network in gate order; gates only reference lower-numbered gates.
    function automatic logic f_net(input logic [N_IN-1:0]                 x,
                                   input logic [N_GATES-1:0][3*SEL_W-1:0] sel,
                                   input logic [N_GATES-1:0][2:0]         inv);
        logic [V_W-1:0] v;
        logic [2:0]     o;
        v = '0;
        v[N_IN-1:0] = x;
        for (int k = 0; k < int'(N_GATES); k++) begin
            for (int j = 0; j < 3; j++) begin
                o[j] = v[sel[k][j*SEL_W +: SEL_W]] ^ inv[k][j];
            end
            v[N_IN+1+k] = (o[0] & o[1]) | (o[0] & o[2]) | (o[1] & o[2]);
        end
        return v[N_IN+N_GATES];
    endfunction

    assign w_scan_y = f_net(r_cnt, r_sel, w_inv);
    assign w_eval_y = f_net(eval_x, r_sel, w_inv);

    // A write is legal only for an existing gate whose operands point strictly backwards.
    always_comb begin
        w_cfg_ok = (32'(cfg_gate) < N_GATES);
        for (int j = 0; j < 3; j++) begin
            if (32'(cfg_op[j*SEL_W +: SEL_W]) >= N_IN + 1 + 32'(cfg_gate)) begin
                w_cfg_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_tt      <= '0;
            r_eval_y  <= 1'b0;
            for (int k = 0; k < int'(N_GATES); k++) begin
                r_sel[k] <= {3{SEL_W'(N_IN)}};
            end
`ifdef MAJ_INV_EN
            r_inv     <= '0;
`endif
        end else begin
            r_cfg_err <= cfg_we && (r_busy || !w_cfg_ok);
            if (cfg_we && !r_busy && w_cfg_ok) begin
                r_sel[cfg_gate] <= cfg_op[3*SEL_W-1:0];
`ifdef MAJ_INV_EN
                r_inv[cfg_gate] <= cfg_op[3*SEL_W +: 3];
`endif
            end
            r_eval_y <= w_eval_y;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SCAN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_tt    <= '0;
                    end
                end
                SCAN: begin
                    r_tt[r_cnt] <= w_scan_y;
                    r_cnt       <= r_cnt + 1'b1;
                    if (r_cnt == {N_IN{1'b1}}) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_err = r_cfg_err;
    assign busy    = r_busy;
    assign done    = r_done;
    assign tt      = r_tt;
    assign eval_y  = r_eval_y;

endmodule
